// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - multi-master memory arbiter, fixed-priority or round-robin
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = 32,
    parameter int RR_MODE    = 0
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_m_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_m_data,
    input  logic [NUM_PORTS-1:0]            i_m_wr_valid,
    output logic [NUM_PORTS-1:0]            o_m_wr_ready,
    input  logic [NUM_PORTS*3-1:0]          i_m_wr_width,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] o_m_data,
    output logic [NUM_PORTS-1:0]            o_m_rd_valid,
    input  logic [NUM_PORTS-1:0]            i_m_rd_ready,
    input  logic [NUM_PORTS-1:0]            i_m_lock,
    output logic [ADDR_WIDTH-1:0]           o_addr,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic                            o_wr_valid,
    input  logic                            i_wr_ready,
    output logic [2:0]                      o_wr_width,
    input  logic [DATA_WIDTH-1:0]           i_data,
    input  logic                            i_rd_valid,
    output logic                            o_rd_ready,
    output logic [NUM_PORTS-1:0]            o_grant,
    output logic                            o_busy
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_OWNED = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NUM_PORTS-1:0] req;
    logic [PW-1:0]        gidx;
    logic [PW-1:0]        win_idx;
    logic                 found;
    logic                 owned;
    logic                 complete;
    int                   cand;

    assign req      = i_m_wr_valid | i_m_rd_ready;
    assign owned    = (state_q == ST_OWNED);
    assign o_grant  = grant_q;
    assign o_busy   = owned;
    assign complete = (o_wr_valid & i_wr_ready) | (o_rd_ready & i_rd_valid);

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (grant_q[i]) gidx = PW'(i);
    end

    // Search starts at ptr in round-robin mode, at port 0 otherwise
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = k + ((RR_MODE != 0) ? int'(ptr_q) : 0);
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = PW'(cand);
            end
        end
    end

    always_comb begin
        o_addr     = '0;
        o_data     = '0;
        o_wr_valid = 1'b0;
        o_wr_width = '0;
        o_rd_ready = 1'b0;
        if (owned) begin
            o_addr     = i_m_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
            o_data     = i_m_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
            o_wr_valid = i_m_wr_valid[gidx];
            o_wr_width = i_m_wr_width[int'(gidx)*3 +: 3];
            o_rd_ready = i_m_rd_ready[gidx];
        end
    end

    always_comb begin
        o_m_wr_ready = '0;
        o_m_data     = '0;
        o_m_rd_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (owned && grant_q[i]) begin
                o_m_wr_ready[i]                       = i_wr_ready;
                o_m_data[i*DATA_WIDTH +: DATA_WIDTH]  = i_data;
                o_m_rd_valid[i]                       = i_rd_valid;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_OWNED;
                    grant_d = NUM_PORTS'(1) << win_idx;
                    if (RR_MODE != 0)
                        ptr_d = (win_idx == PW'(NUM_PORTS - 1)) ? '0 : win_idx + PW'(1);
                end
            end
            ST_OWNED: begin
                // A locked owner keeps the bus even with no request outstanding
                if (complete ? !i_m_lock[gidx] : (!req[gidx] && !i_m_lock[gidx])) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter (fixed 2-port and round-robin 4-port)
module tb_mem_arbiter;
    logic clk;
    logic rst_n;

    logic [31:0] f_maddr, f_mdin, f_mdout;
    logic [1:0]  f_wv, f_mwr, f_mrv, f_rr, f_lk, f_grant;
    logic [5:0]  f_wid;
    logic [15:0] f_oaddr, f_odata, f_idata;
    logic [2:0]  f_owid;
    logic        f_owv, f_wrdy, f_rvld, f_ordr, f_busy;

    logic [63:0] r_maddr, r_mdin, r_mdout;
    logic [3:0]  r_wv, r_mwr, r_mrv, r_rr, r_lk, r_grant;
    logic [11:0] r_wid;
    logic [15:0] r_oaddr, r_odata, r_idata;
    logic [2:0]  r_owid;
    logic        r_owv, r_wrdy, r_rvld, r_ordr, r_busy;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(16), .ADDR_WIDTH(16), .RR_MODE(0)) u_fix (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m_addr(f_maddr), .i_m_data(f_mdin), .i_m_wr_valid(f_wv), .o_m_wr_ready(f_mwr),
        .i_m_wr_width(f_wid), .o_m_data(f_mdout), .o_m_rd_valid(f_mrv), .i_m_rd_ready(f_rr),
        .i_m_lock(f_lk), .o_addr(f_oaddr), .o_data(f_odata), .o_wr_valid(f_owv),
        .i_wr_ready(f_wrdy), .o_wr_width(f_owid), .i_data(f_idata), .i_rd_valid(f_rvld),
        .o_rd_ready(f_ordr), .o_grant(f_grant), .o_busy(f_busy)
    );

    mem_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(16), .ADDR_WIDTH(16), .RR_MODE(1)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m_addr(r_maddr), .i_m_data(r_mdin), .i_m_wr_valid(r_wv), .o_m_wr_ready(r_mwr),
        .i_m_wr_width(r_wid), .o_m_data(r_mdout), .o_m_rd_valid(r_mrv), .i_m_rd_ready(r_rr),
        .i_m_lock(r_lk), .o_addr(r_oaddr), .o_data(r_odata), .o_wr_valid(r_owv),
        .i_wr_ready(r_wrdy), .o_wr_width(r_owid), .i_data(r_idata), .i_rd_valid(r_rvld),
        .o_rd_ready(r_ordr), .o_grant(r_grant), .o_busy(r_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // own: 0 = idle, 1 = port 0 owns, 2 = port 1 owns
    typedef struct {
        logic [1:0] wv, rr, lk;
        logic       wrdy, rvld;
        logic [1:0] own;
        logic       ewv, erdr;
        logic [1:0] emrv, emwr;
    } vec_t;

    vec_t vec[20];
    logic [3:0] rr_exp[9];

    logic [1:0]  e_grant;
    logic [15:0] e_addr, e_od;
    logic [2:0]  e_wid;
    logic [31:0] e_md;

    initial begin
        vec[0]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[1]  = '{2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[2]  = '{2'b00, 2'b11, 2'b00, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2'b01, 2'b00};
        vec[3]  = '{2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[4]  = '{2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'b10, 2'b00};
        vec[5]  = '{2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[6]  = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 2'b00, 2'b00};
        vec[7]  = '{2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 2'b00, 2'b01};
        vec[8]  = '{2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[9]  = '{2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 2'b00, 2'b00};
        vec[10] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 2'b00, 2'b10};
        vec[11] = '{2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[12] = '{2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 2'b01, 2'b00};
        vec[13] = '{2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[14] = '{2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 2'b00, 2'b10};
        vec[15] = '{2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[16] = '{2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[17] = '{2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'b00};
        vec[18] = '{2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2'b01, 2'b00};
        vec[19] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'b00};
        rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

        f_maddr = {16'h2000, 16'h1000};
        f_mdin  = {16'h5555, 16'hAAAA};
        f_wid   = {3'd5, 3'd2};
        f_idata = 16'hBEEF;
        r_maddr = {16'h4300, 16'h4200, 16'h4100, 16'h4000};
        r_mdin  = {16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0};
        r_wid   = {3'd7, 3'd6, 3'd5, 3'd4};
        r_idata = 16'hCAFE;

        // Reset with requests asserted: everything must stay quiet
        rst_n = 1'b0;
        f_wv = 2'b11; f_rr = 2'b11; f_lk = 2'b00; f_wrdy = 1'b1; f_rvld = 1'b1;
        r_wv = 4'h0;  r_rr = 4'hF;  r_lk = 4'h0;  r_wrdy = 1'b1; r_rvld = 1'b1;
        @(negedge clk); #1;
        chk("rst_f_grant", 0, 64'(f_grant), 64'd0);
        chk("rst_f_busy",  0, 64'(f_busy),  64'd0);
        chk("rst_f_owv",   0, 64'(f_owv),   64'd0);
        chk("rst_f_ordr",  0, 64'(f_ordr),  64'd0);
        chk("rst_f_mrv",   0, 64'(f_mrv),   64'd0);
        chk("rst_f_mwr",   0, 64'(f_mwr),   64'd0);
        chk("rst_r_grant", 0, 64'(r_grant), 64'd0);
        chk("rst_r_mdout", 0, 64'(r_mdout), 64'd0);
        f_wv = '0; f_rr = '0; f_wrdy = 1'b0; f_rvld = 1'b0;
        r_rr = '0; r_wrdy = 1'b0; r_rvld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 20; r++) begin
            @(negedge clk);
            f_wv = vec[r].wv; f_rr = vec[r].rr; f_lk = vec[r].lk;
            f_wrdy = vec[r].wrdy; f_rvld = vec[r].rvld;
            #1;
            e_grant = (vec[r].own == 2'd1) ? 2'b01 : (vec[r].own == 2'd2) ? 2'b10 : 2'b00;
            e_addr  = (vec[r].own == 2'd1) ? 16'h1000 : (vec[r].own == 2'd2) ? 16'h2000 : 16'h0;
            e_od    = (vec[r].own == 2'd1) ? 16'hAAAA : (vec[r].own == 2'd2) ? 16'h5555 : 16'h0;
            e_wid   = (vec[r].own == 2'd1) ? 3'd2 : (vec[r].own == 2'd2) ? 3'd5 : 3'd0;
            e_md    = (vec[r].own == 2'd1) ? 32'h0000BEEF : (vec[r].own == 2'd2) ? 32'hBEEF0000 : 32'h0;
            chk("vec_grant", r, 64'(f_grant), 64'(e_grant));
            chk("vec_busy",  r, 64'(f_busy),  64'(vec[r].own != 2'd0));
            chk("vec_addr",  r, 64'(f_oaddr), 64'(e_addr));
            chk("vec_odata", r, 64'(f_odata), 64'(e_od));
            chk("vec_width", r, 64'(f_owid),  64'(e_wid));
            chk("vec_owv",   r, 64'(f_owv),   64'(vec[r].ewv));
            chk("vec_ordr",  r, 64'(f_ordr),  64'(vec[r].erdr));
            chk("vec_mrv",   r, 64'(f_mrv),   64'(vec[r].emrv));
            chk("vec_mwr",   r, 64'(f_mwr),   64'(vec[r].emwr));
            chk("vec_mdata", r, 64'(f_mdout), 64'(e_md));
        end

        // Round-robin rotation with all four ports reading and single-cycle completions
        @(negedge clk);
        r_rr = 4'hF; r_rvld = 1'b1;
        #1 chk("rr_idle", 0, 64'(r_grant), 64'd0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk); #1;
            chk("rr_grant", k, 64'(r_grant), 64'(rr_exp[k]));
            chk("rr_mrv",   k, 64'(r_mrv),   64'(rr_exp[k]));
        end

        // Locked writer on port 2 holds the bus while port 0 waits
        @(negedge clk);
        r_rr = 4'h0; r_rvld = 1'b0; r_wv = 4'b0100; r_lk = 4'b0100; r_wrdy = 1'b0;
        #1 chk("lock_idle", 0, 64'(r_grant), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            r_rr = 4'b0001; r_wrdy = 1'b1;
            #1;
            chk("lock_grant",  k, 64'(r_grant), 64'b0100);
            chk("lock_wready", k, 64'(r_mwr),   64'b0100);
            chk("lock_addr",   k, 64'(r_oaddr), 64'h4200);
            chk("lock_data",   k, 64'(r_odata), 64'hD2D2);
            chk("lock_width",  k, 64'(r_owid),  64'd6);
        end
        @(negedge clk);
        r_wv = 4'h0; r_lk = 4'h0; r_wrdy = 1'b0;
        #1 chk("lock_hold", 0, 64'(r_grant), 64'b0100);
        @(negedge clk); #1 chk("lock_bubble", 0, 64'(r_grant), 64'd0);
        @(negedge clk); #1;
        chk("lock_next", 0, 64'(r_grant), 64'b0001);
        chk("lock_busy", 0, 64'(r_busy),  64'd1);
        chk("lock_ordr", 0, 64'(r_ordr),  64'd1);

        // Asynchronous reset in the middle of an owned read
        #1 rst_n = 1'b0;
        #1;
        chk("arst_grant", 0, 64'(r_grant), 64'd0);
        chk("arst_busy",  0, 64'(r_busy),  64'd0);
        chk("arst_ordr",  0, 64'(r_ordr),  64'd0);
        chk("arst_addr",  0, 64'(r_oaddr), 64'd0);
        r_rr = 4'hF;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst_rel", 0, 64'(r_grant), 64'd0);
        @(negedge clk); #1 chk("arst_first", 0, 64'(r_grant), 64'b0001);
        r_rr = 4'h0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of memory masters (legal 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, data bus width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-004 SHALL have parameter RR_MODE, default 0; 0 = fixed priority, 1 = round-robin.
REQ-005 SHALL use one clock and an asynchronous active-low reset:
  i_clk  in  1  clock, all state on rising edge
  i_rst_n  in  1  asynchronous active-low reset
REQ-006 SHALL have master-side ports. Port i occupies slice [i*W +: W] of each packed bus.
  i_m_addr  in  NUM_PORTS*ADDR_WIDTH  master addresses
  i_m_data  in  NUM_PORTS*DATA_WIDTH  master write data
  i_m_wr_valid  in  NUM_PORTS  write request
  o_m_wr_ready  out  NUM_PORTS  write accepted
  i_m_wr_width  in  NUM_PORTS*3  write width code
  o_m_data  out  NUM_PORTS*DATA_WIDTH  read data
  o_m_rd_valid  out  NUM_PORTS  read data valid
  i_m_rd_ready  in  NUM_PORTS  read request
  i_m_lock  in  NUM_PORTS  hold grant after completion
REQ-007 SHALL have memory-side ports.
  o_addr  out  ADDR_WIDTH; o_data  out  DATA_WIDTH; o_wr_valid  out  1; i_wr_ready  in  1; o_wr_width  out  3
  i_data  in  DATA_WIDTH; i_rd_valid  in  1; o_rd_ready  out  1
REQ-008 SHALL have status outputs.
  o_grant  out  NUM_PORTS  registered one-hot owner, 0 when idle
  o_busy  out  1  high in OWNED

Function
REQ-009 SHALL treat port i as requesting when i_m_wr_valid[i] | i_m_rd_ready[i].
REQ-010 SHALL implement a two-state FSM, IDLE and OWNED.
REQ-011 SHALL arbitrate in IDLE when any port requests; winner registered into o_grant; state OWNED next edge (1-cycle grant latency).
REQ-012 SHALL, with RR_MODE=0, grant the lowest-index requester.
REQ-013 SHALL, with RR_MODE=1:
  - search from pointer ptr upward, wrapping NUM_PORTS-1 -> 0
  - set ptr = (winner+1) mod NUM_PORTS on each grant
REQ-014 SHALL, in OWNED, route the memory side combinationally to granted port g:
  - memory outputs = port g's addr/data/wr_valid/wr_width/rd_ready
  - port g receives i_wr_ready, i_data, i_rd_valid
REQ-015 SHALL drive zero on every non-granted master output and, in IDLE, on all memory outputs.
REQ-016 SHALL define completion as (o_wr_valid & i_wr_ready) | (o_rd_ready & i_rd_valid) in one cycle.
REQ-017 SHALL, on completion, go to IDLE next edge if i_m_lock[g]=0 (one bubble cycle before next grant); if i_m_lock[g]=1, stay OWNED, same g.
REQ-018 SHALL release to IDLE when port g has neither request nor lock (abandoned request).
REQ-019 SHALL not preempt: requests from other ports while OWNED wait; no port change without passing IDLE.
REQ-020 SHALL forward simultaneous read and write from g unchanged; either handshake counts as completion.

Reset
REQ-021 SHALL, while i_rst_n=0, asynchronously force: state IDLE, o_grant=0, o_busy=0, ptr=0, all memory and master outputs 0.
REQ-022 SHALL drop any in-flight transaction when reset asserts mid-OWNED; after release, arbitration restarts from IDLE with ptr=0.

Verification
REQ-023 Fixed mode, ports 0 and 1 read at once, i_rd_valid 1 cycle later -> o_grant=01 one cycle after request; port 0 gets i_data; IDLE; then o_grant=10.
REQ-024 RR_MODE=1, NUM_PORTS=4, all ports request continuously, single-cycle completions -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-025 Port 2 write, i_m_lock[2]=1 for 3 writes, port 0 also requesting -> o_grant stays 100 for all 3 handshakes; port 0 granted only after lock drops.
REQ-026 Port 1 granted, request dropped before i_wr_ready -> IDLE next edge, o_grant=0, no write reaches memory.
REQ-027 i_rst_n pulled low mid-OWNED, async to clock -> all outputs 0 before next edge; after release, RR grant starts at port 0.
